// File: rtl/accum_unit.sv
// Command-driven accumulator front-end for a 4-bit two's-complement add/sub datapath.
// Commands queue in a small FIFO and execute one per cycle; overflow can optionally halt execution.

module accum_addsub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       ovf
);
  logic [3:0] b_x;
  logic [4:0] sum;

  assign b_x = b ^ {4{c0}};
  assign sum = {1'b0, a} + {1'b0, b_x} + {4'b0000, c0};
  assign s   = sum[3:0];
  // Signed overflow: both operands share a sign that the result does not.
  assign ovf = (a[3] == b_x[3]) && (s[3] != a[3]);
endmodule

module accum_unit #(
  parameter int DEPTH       = 4,
  parameter bit HALT_ON_OVF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_op,
  input  logic [3:0] in_data,
  input  logic       clr_ovf,
  output logic [3:0] acc,
  output logic       res_valid,
  output logic       res_ovf,
  output logic       ovf_flag,
  output logic       halted
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    acc_q, acc_d;
  logic          res_valid_q, res_valid_d;
  logic          res_ovf_q, res_ovf_d;
  logic          ovf_flag_q, ovf_flag_d;
  logic          halted_q, halted_d;
  logic          in_ready_q, in_ready_d;

  logic          push_s, pop_s;
  logic [5:0]    head_s;
  logic [1:0]    head_op_s;
  logic [3:0]    head_data_s;
  logic          as_sub_s;
  logic [3:0]    as_sum_s;
  logic          as_ovf_s;
  logic [3:0]    op_result_s;
  logic          op_ovf_s;

  assign head_s      = mem_q[rd_ptr_q];
  assign head_op_s   = head_s[5:4];
  assign head_data_s = head_s[3:0];
  assign as_sub_s    = (head_op_s == OP_SUB);

  accum_addsub u_addsub (
    .a   (acc_q),
    .b   (head_data_s),
    .c0  (as_sub_s),
    .s   (as_sum_s),
    .ovf (as_ovf_s)
  );

  always_comb begin
    push_s = in_valid && (count_q < CW'(DEPTH));
    pop_s  = (state_q == S_RUN) && (count_q != {CW{1'b0}});

    case (head_op_s)
      OP_LOAD:  begin op_result_s = head_data_s; op_ovf_s = 1'b0;     end
      OP_ADD:   begin op_result_s = as_sum_s;    op_ovf_s = as_ovf_s; end
      OP_SUB:   begin op_result_s = as_sum_s;    op_ovf_s = as_ovf_s; end
      OP_CLEAR: begin op_result_s = 4'b0000;     op_ovf_s = 1'b0;     end
      default:  begin op_result_s = 4'b0000;     op_ovf_s = 1'b0;     end
    endcase

    acc_d    = pop_s  ? op_result_s         : acc_q;
    wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A set from an executing overflow takes priority over a same-cycle clear.
    if (pop_s && op_ovf_s) begin
      ovf_flag_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_flag_d = 1'b0;
    end else begin
      ovf_flag_d = ovf_flag_q;
    end

    case (state_q)
      S_IDLE: begin
        state_d = (count_d != {CW{1'b0}}) ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (pop_s && op_ovf_s && HALT_ON_OVF) begin
          state_d = S_HALT;
        end else if (count_d == {CW{1'b0}}) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_HALT: begin
        if (clr_ovf) begin
          state_d = (count_d != {CW{1'b0}}) ? S_RUN : S_IDLE;
        end else begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    res_valid_d = pop_s;
    res_ovf_d   = pop_s && op_ovf_s;
    halted_d    = (state_d == S_HALT);
    in_ready_d  = (count_d < CW'(DEPTH));
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {in_op, in_data};
    end
  end

  // Control state, pointers, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      acc_q       <= 4'b0000;
      res_valid_q <= 1'b0;
      res_ovf_q   <= 1'b0;
      ovf_flag_q  <= 1'b0;
      halted_q    <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
      res_ovf_q   <= res_ovf_d;
      ovf_flag_q  <= ovf_flag_d;
      halted_q    <= halted_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign acc       = acc_q;
  assign res_valid = res_valid_q;
  assign res_ovf   = res_ovf_q;
  assign ovf_flag  = ovf_flag_q;
  assign halted    = halted_q;
  assign in_ready  = in_ready_q;
endmodule

// File: tb/tb_accum_unit.sv
// Bench for accum_unit: two instances (halting and non-halting) share one directed stimulus,
// checked every cycle against a queue-based model plus hand-computed literal expectations.

module tb_accum_unit;
  localparam int DEPTH = 4;
  localparam logic [1:0] LD = 2'b00;
  localparam logic [1:0] AD = 2'b01;
  localparam logic [1:0] SB = 2'b10;

  logic       clk = 1'b0;
  logic       rst, in_valid, clr_ovf;
  logic [1:0] in_op;
  logic [3:0] in_data;
  logic       rdy0, rdy1, rv0, rv1, rovf0, rovf1, flag0, flag1, halt0, halt1;
  logic [3:0] acc0, acc1;

  always #5 clk = ~clk;

  accum_unit #(.DEPTH(DEPTH), .HALT_ON_OVF(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_op(in_op),
    .in_data(in_data), .clr_ovf(clr_ovf), .acc(acc0), .res_valid(rv0),
    .res_ovf(rovf0), .ovf_flag(flag0), .halted(halt0)
  );

  accum_unit #(.DEPTH(DEPTH), .HALT_ON_OVF(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_op(in_op),
    .in_data(in_data), .clr_ovf(clr_ovf), .acc(acc1), .res_valid(rv1),
    .res_ovf(rovf1), .ovf_flag(flag1), .halted(halt1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: a command queue per instance plus architectural results.
  int q0[$];
  int q1[$];
  bit m_on = 1'b0;
  bit m_hoo[2]  = '{1'b1, 1'b0};
  int m_acc[2]  = '{0, 0};
  bit m_rv[2]   = '{1'b0, 1'b0};
  bit m_rovf[2] = '{1'b0, 1'b0};
  bit m_flag[2] = '{1'b0, 1'b0};
  bit m_halt[2] = '{1'b0, 1'b0};

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int to_signed(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  task automatic model_one(input int i);
    int sz, cmd, op, d, r;
    bit ex, ov;
    if (rst) begin
      if (i == 0) q0.delete(); else q1.delete();
      m_acc[i] = 0; m_rv[i] = 1'b0; m_rovf[i] = 1'b0; m_flag[i] = 1'b0; m_halt[i] = 1'b0;
    end else begin
      sz = q_size(i);
      ex = !m_halt[i] && (sz > 0);
      ov = 1'b0;
      if (ex) begin
        cmd = (i == 0) ? q0.pop_front() : q1.pop_front();
        op = cmd / 16;
        d  = cmd % 16;
        if (op == 0) m_acc[i] = d;
        else if (op == 3) m_acc[i] = 0;
        else begin
          r = (op == 1) ? to_signed(m_acc[i]) + to_signed(d) : to_signed(m_acc[i]) - to_signed(d);
          ov = (r > 7) || (r < -8);
          m_acc[i] = (r + 32) % 16;
        end
      end
      if (in_valid && sz < DEPTH) begin
        if (i == 0) q0.push_back(int'(in_op) * 16 + int'(in_data));
        else q1.push_back(int'(in_op) * 16 + int'(in_data));
      end
      m_rv[i]   = ex;
      m_rovf[i] = ex && ov;
      if (ex && ov) m_flag[i] = 1'b1;
      else if (clr_ovf) m_flag[i] = 1'b0;
      if (ex && ov && m_hoo[i]) m_halt[i] = 1'b1;
      else if (clr_ovf) m_halt[i] = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) m_on = 1'b1;
    if (m_on) begin
      model_one(0);
      model_one(1);
    end
  end

  function automatic int pack(input int a, input bit v, input bit o, input bit f, input bit h, input bit r);
    return a * 32 + int'(v) * 16 + int'(o) * 8 + int'(f) * 4 + int'(h) * 2 + int'(r);
  endfunction

  // Per-cycle comparison of every output against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_on) begin
      chk("model_dut0", pack(acc0, rv0, rovf0, flag0, halt0, rdy0),
          pack(m_acc[0], m_rv[0], m_rovf[0], m_flag[0], m_halt[0], q0.size() < DEPTH));
      chk("model_dut1", pack(acc1, rv1, rovf1, flag1, halt1, rdy1),
          pack(m_acc[1], m_rv[1], m_rovf[1], m_flag[1], m_halt[1], q1.size() < DEPTH));
    end
  end

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] d, input logic c);
    in_valid = v; in_op = op; in_data = d; clr_ovf = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, LD, 4'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_data = 4'h0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", acc0, 0);
    chk("rst_rv", rv0, 0);
    chk("rst_ready", rdy0, 1);
    chk("rst_halt_flag", {halt0, flag0}, 0);
    rst = 1'b0;

    // LOAD 5, ADD 2 back to back
    drive(1'b1, LD, 4'd5, 1'b0);
    drive(1'b1, AD, 4'd2, 1'b0);
    chk("t1_load_acc", acc0, 5);
    chk("t1_load_rv", rv0, 1);
    idle(1);
    chk("t1_add_acc", acc0, 7);
    chk("t1_add_rv_ovf_flag", {rv0, rovf0, flag0}, 3'b100);
    idle(1);
    chk("t1_rv_drop", rv0, 0);

    // LOAD 7, ADD 1 overflows and halts; queued ADD 1 waits for clr_ovf
    drive(1'b1, LD, 4'd7, 1'b0);
    drive(1'b1, AD, 4'd1, 1'b0);
    drive(1'b1, AD, 4'd1, 1'b0);
    chk("t2_ovf_acc", acc0, 8);
    chk("t2_ovf_bits", {rovf0, flag0, halt0}, 3'b111);
    chk("t2_nohalt_dut1", halt1, 0);
    idle(2);
    chk("t2_held_acc", acc0, 8);
    chk("t2_held_rv", rv0, 0);
    chk("t2_dut1_ran", acc1, 9);
    drive(1'b0, LD, 4'h0, 1'b1);
    chk("t2_released", {halt0, flag0}, 0);
    idle(1);
    chk("t2_resume_acc", acc0, 9);
    chk("t2_resume_rv", {rv0, rovf0}, 2'b10);
    idle(2);

    // LOAD -8, SUB 1 overflows; LOAD 3, SUB 5 gives -2
    drive(1'b1, LD, 4'b1000, 1'b0);
    drive(1'b1, SB, 4'd1, 1'b0);
    idle(1);
    chk("t3_sub_ovf_acc", acc0, 7);
    chk("t3_sub_ovf", rovf0, 1);
    drive(1'b0, LD, 4'h0, 1'b1);
    drive(1'b1, LD, 4'd3, 1'b0);
    drive(1'b1, SB, 4'd5, 1'b0);
    idle(1);
    chk("t3_sub_acc", acc0, 14);
    chk("t3_sub_bits", {rv0, rovf0}, 2'b10);
    idle(2);

    // Fill the FIFO while halted
    drive(1'b1, LD, 4'd7, 1'b0);
    drive(1'b1, AD, 4'd1, 1'b0);
    idle(1);
    chk("t4_halted", halt0, 1);
    drive(1'b1, LD, 4'd1, 1'b0);
    drive(1'b1, AD, 4'd2, 1'b0);
    drive(1'b1, SB, 4'd1, 1'b0);
    chk("t4_ready_3", rdy0, 1);
    drive(1'b1, AD, 4'd3, 1'b0);
    chk("t4_full", rdy0, 0);
    drive(1'b1, LD, 4'hF, 1'b0);
    chk("t4_still_full", rdy0, 0);
    drive(1'b0, LD, 4'h0, 1'b1);
    chk("t4_unhalt", halt0, 0);
    idle(1);
    chk("t4_r1", {acc0, rv0, rdy0}, {4'd1, 1'b1, 1'b1});
    idle(1);
    chk("t4_r2", {acc0, rv0}, {4'd3, 1'b1});
    idle(1);
    chk("t4_r3", {acc0, rv0}, {4'd2, 1'b1});
    idle(1);
    chk("t4_r4", {acc0, rv0}, {4'd5, 1'b1});
    idle(1);
    chk("t4_extra_dropped", {acc0, rv0}, {4'd5, 1'b0});
    idle(2);

    // clr_ovf coincident with an overflowing op
    drive(1'b1, LD, 4'd7, 1'b0);
    drive(1'b1, AD, 4'd1, 1'b0);
    drive(1'b1, AD, 4'd1, 1'b1);
    chk("t5_set_wins_dut0", {flag0, halt0}, 2'b11);
    chk("t5_set_wins_dut1", {flag1, halt1}, 2'b10);
    idle(1);
    chk("t5_dut0_held", {acc0, rv0}, {4'd8, 1'b0});
    chk("t5_dut1_runs", {acc1, rv1}, {4'd9, 1'b1});
    drive(1'b0, LD, 4'h0, 1'b1);
    idle(1);
    chk("t5_dut0_resume", acc0, 9);
    idle(2);

    // Reset with queued commands discards them
    drive(1'b1, LD, 4'b1000, 1'b0);
    drive(1'b1, SB, 4'd2, 1'b0);
    idle(1);
    chk("t6_acc_pre", {acc0, halt0}, {4'b0110, 1'b1});
    drive(1'b1, AD, 4'd1, 1'b0);
    drive(1'b1, AD, 4'd2, 1'b0);
    drive(1'b1, AD, 4'd3, 1'b0);
    rst = 1'b1;
    drive(1'b0, LD, 4'h0, 1'b0);
    rst = 1'b0;
    chk("t6_rst_acc", acc0, 0);
    chk("t6_rst_bits", {rv0, flag0, halt0, rdy0}, 4'b0001);
    idle(3);
    chk("t6_discarded", {acc0, rv0, acc1, rv1}, 10'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
